// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Parametrised VGA raster timing generator. A pixel-enable divider drives
//   horizontal and vertical position counters. Every output is a register
//   loaded from the same counter state, so all outputs are cycle-aligned and
//   lag the counters by one clock.
//
// Ports
//   clk         : system clock
//   reset       : synchronous, active-low reset
//   hsync       : horizontal sync, active level H_POL
//   vsync       : vertical sync, active level V_POL
//   video_on    : pix_x < H_DISPLAY and pix_y < V_DISPLAY
//   pixel_tick  : high in the last system clock of each pixel period
//   pix_x       : current column, 0..H_TOTAL-1
//   pix_y       : current line, 0..V_TOTAL-1
//   line_start  : one-clock strobe in the first clock of pixel x=0
//   frame_start : one-clock strobe in the first clock of pixel (0,0)
module vga_timing_gen #(
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter int unsigned H_POL     = 0,
  parameter int unsigned V_POL     = 0,
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned CNT_W     = 10
) (
  input  logic             clk,
  input  logic             reset,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic             pixel_tick,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             line_start,
  output logic             frame_start
);

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_DISPLAY);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_DISPLAY);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_DISPLAY + H_FRONT);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_DISPLAY + V_FRONT);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic             H_ACT    = H_POL[0];
  localparam logic             V_ACT    = V_POL[0];

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic             tick;

  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             video_on_q, video_on_d;
  logic             pixel_tick_q, pixel_tick_d;
  logic [CNT_W-1:0] pix_x_q, pix_x_d;
  logic [CNT_W-1:0] pix_y_q, pix_y_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;

  // With CLK_DIV=1 the divider is a single bit that stays 0, so tick is
  // permanently high.
  always_comb begin
    tick      = (div_cnt_q == DIV_LAST);
    div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    if (tick) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CNT_W'(1);
      end else begin
        h_cnt_d = h_cnt_q + CNT_W'(1);
      end
    end
  end

  // Output decode works on the current counters; the registers below add the
  // single clock of latency shared by every output.
  always_comb begin
    hsync_d       = ((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST)) ? H_ACT : ~H_ACT;
    vsync_d       = ((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST)) ? V_ACT : ~V_ACT;
    video_on_d    = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    pixel_tick_d  = tick;
    pix_x_d       = h_cnt_q;
    pix_y_d       = v_cnt_q;
    line_start_d  = (h_cnt_q == '0) && (div_cnt_q == '0);
    frame_start_d = line_start_d && (v_cnt_q == '0);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt_q     <= '0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      hsync_q       <= ~H_ACT;
      vsync_q       <= ~V_ACT;
      video_on_q    <= 1'b0;
      pixel_tick_q  <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      pixel_tick_q  <= pixel_tick_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign pixel_tick  = pixel_tick_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // default timing, CLK_DIV=2
  logic rst_d;
  logic hs_d, vs_d, vo_d, pt_d, ls_d, fs_d;
  logic [9:0] px_d, py_d;
  // small timing, CLK_DIV=1, active-low syncs
  logic rst_s;
  logic hs_s, vs_s, vo_s, pt_s, ls_s, fs_s;
  logic [9:0] px_s, py_s;
  // small timing, CLK_DIV=1, active-high syncs
  logic rst_p;
  logic hs_p, vs_p, vo_p, pt_p, ls_p, fs_p;
  logic [9:0] px_p, py_p;
  // default timing, CLK_DIV=3
  logic rst_3;
  logic hs_3, vs_3, vo_3, pt_3, ls_3, fs_3;
  logic [9:0] px_3, py_3;

  vga_timing_gen u_def (
    .clk(clk), .reset(rst_d), .hsync(hs_d), .vsync(vs_d), .video_on(vo_d),
    .pixel_tick(pt_d), .pix_x(px_d), .pix_y(py_d), .line_start(ls_d), .frame_start(fs_d)
  );

  vga_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .CLK_DIV(1), .CNT_W(10)
  ) u_small (
    .clk(clk), .reset(rst_s), .hsync(hs_s), .vsync(vs_s), .video_on(vo_s),
    .pixel_tick(pt_s), .pix_x(px_s), .pix_y(py_s), .line_start(ls_s), .frame_start(fs_s)
  );

  vga_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_POL(1), .V_POL(1), .CLK_DIV(1), .CNT_W(10)
  ) u_pol (
    .clk(clk), .reset(rst_p), .hsync(hs_p), .vsync(vs_p), .video_on(vo_p),
    .pixel_tick(pt_p), .pix_x(px_p), .pix_y(py_p), .line_start(ls_p), .frame_start(fs_p)
  );

  vga_timing_gen #(.CLK_DIV(3)) u_div3 (
    .clk(clk), .reset(rst_3), .hsync(hs_3), .vsync(vs_3), .video_on(vo_3),
    .pixel_tick(pt_3), .pix_x(px_3), .pix_y(py_3), .line_start(ls_3), .frame_start(fs_3)
  );

  task automatic test_reset();
    rst_d = 1'b0; rst_s = 1'b0; rst_p = 1'b0; rst_3 = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (px_d !== 10'd0) begin bad++; $display("FAIL rst_pix_x got=%0d want=0", px_d); end
    total++; if (py_d !== 10'd0) begin bad++; $display("FAIL rst_pix_y got=%0d want=0", py_d); end
    total++; if (hs_d !== 1'b1) begin bad++; $display("FAIL rst_hsync got=%b want=1", hs_d); end
    total++; if (vs_d !== 1'b1) begin bad++; $display("FAIL rst_vsync got=%b want=1", vs_d); end
    total++; if (vo_d !== 1'b0) begin bad++; $display("FAIL rst_video_on got=%b want=0", vo_d); end
    total++; if (pt_d !== 1'b0) begin bad++; $display("FAIL rst_pixel_tick got=%b want=0", pt_d); end
    total++; if (ls_d !== 1'b0) begin bad++; $display("FAIL rst_line_start got=%b want=0", ls_d); end
    total++; if (fs_d !== 1'b0) begin bad++; $display("FAIL rst_frame_start got=%b want=0", fs_d); end
    total++; if (pt_s !== 1'b0) begin bad++; $display("FAIL rst_small_tick got=%b want=0", pt_s); end
    total++; if (hs_p !== 1'b0) begin bad++; $display("FAIL rst_pol_hsync got=%b want=0", hs_p); end
    total++; if (vs_p !== 1'b0) begin bad++; $display("FAIL rst_pol_vsync got=%b want=0", vs_p); end
  endtask

  // Sample index c counts negedges after the first post-release posedge.
  task automatic test_default_line();
    int hs_cnt = 0, hs_first = -1, hs_first_x = -1, hs_last_x = -1;
    int vo_fall_x = -1, vo_prev_x = -1, prev_x = 0;
    int ls_n = 0, ls_prev = 0, ls_gap_bad = 0, fs_extra = 0;
    rst_d = 1'b1;
    for (int c = 0; c < 3300; c++) begin
      @(negedge clk);
      if (c == 0) begin
        total++; if (px_d !== 10'd0 || py_d !== 10'd0) begin bad++; $display("FAIL first_xy got=%0d,%0d want=0,0", px_d, py_d); end
        total++; if (vo_d !== 1'b1) begin bad++; $display("FAIL first_video_on got=%b want=1", vo_d); end
        total++; if (ls_d !== 1'b1) begin bad++; $display("FAIL first_line_start got=%b want=1", ls_d); end
        total++; if (fs_d !== 1'b1) begin bad++; $display("FAIL first_frame_start got=%b want=1", fs_d); end
        total++; if (pt_d !== 1'b0) begin bad++; $display("FAIL first_tick got=%b want=0", pt_d); end
      end
      if (c == 1) begin
        total++; if (px_d !== 10'd0 || pt_d !== 1'b1) begin bad++; $display("FAIL c1 x/tick got=%0d/%b want=0/1", px_d, pt_d); end
      end
      if (c == 2) begin
        total++; if (px_d !== 10'd1) begin bad++; $display("FAIL c2_pix_x got=%0d want=1", px_d); end
      end
      if (c < 1600 && hs_d == 1'b0) begin
        hs_cnt++;
        if (hs_first < 0) begin hs_first = c; hs_first_x = int'(px_d); end
        hs_last_x = int'(px_d);
      end
      if (c < 1600 && vo_fall_x < 0 && vo_d == 1'b0) begin
        vo_fall_x = int'(px_d); vo_prev_x = prev_x;
      end
      prev_x = int'(px_d);
      if (ls_d == 1'b1) begin
        if (ls_n > 0 && (c - ls_prev) != 1600) ls_gap_bad++;
        ls_prev = c; ls_n++;
        if (c == 1600) begin
          total++; if (px_d !== 10'd0 || py_d !== 10'd1) begin bad++; $display("FAIL line2_xy got=%0d,%0d want=0,1", px_d, py_d); end
        end
      end
      if (c > 0 && fs_d == 1'b1) fs_extra++;
    end
    total++; if (hs_cnt != 192) begin bad++; $display("FAIL hsync_width got=%0d want=192", hs_cnt); end
    total++; if (hs_first != 1312) begin bad++; $display("FAIL hsync_first_clk got=%0d want=1312", hs_first); end
    total++; if (hs_first_x != 656) begin bad++; $display("FAIL hsync_first_x got=%0d want=656", hs_first_x); end
    total++; if (hs_last_x != 751) begin bad++; $display("FAIL hsync_last_x got=%0d want=751", hs_last_x); end
    total++; if (vo_fall_x != 640 || vo_prev_x != 639) begin bad++; $display("FAIL video_fall got=%0d->%0d want=639->640", vo_prev_x, vo_fall_x); end
    total++; if (ls_n != 3) begin bad++; $display("FAIL line_start_count got=%0d want=3", ls_n); end
    total++; if (ls_gap_bad != 0) begin bad++; $display("FAIL line_start_gap got=%0d bad gaps want=0", ls_gap_bad); end
    total++; if (fs_extra != 0) begin bad++; $display("FAIL frame_start_extra got=%0d want=0", fs_extra); end
  endtask

  task automatic test_mid_reset();
    bit found = 0;
    for (int i = 0; i < 10000 && !found; i++) begin
      @(negedge clk);
      if (px_d == 10'd300 && py_d == 10'd2) found = 1;
    end
    total++; if (!found) begin bad++; $display("FAIL midrst_wait got=timeout want=pix(300,2)"); end
    rst_d = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (px_d !== 10'd0 || py_d !== 10'd0) begin bad++; $display("FAIL midrst_xy[%0d] got=%0d,%0d want=0,0", i, px_d, py_d); end
      total++; if (hs_d !== 1'b1 || vs_d !== 1'b1 || vo_d !== 1'b0) begin bad++; $display("FAIL midrst_sync[%0d] got=hs%b vs%b vo%b want=hs1 vs1 vo0", i, hs_d, vs_d, vo_d); end
      total++; if (pt_d !== 1'b0 || ls_d !== 1'b0 || fs_d !== 1'b0) begin bad++; $display("FAIL midrst_strobes[%0d] got=pt%b ls%b fs%b want=000", i, pt_d, ls_d, fs_d); end
    end
    rst_d = 1'b1;
    @(negedge clk);
    total++; if (px_d !== 10'd0 || py_d !== 10'd0) begin bad++; $display("FAIL rel_xy got=%0d,%0d want=0,0", px_d, py_d); end
    total++; if (ls_d !== 1'b1 || fs_d !== 1'b1) begin bad++; $display("FAIL rel_strobes got=ls%b fs%b want=ls1 fs1", ls_d, fs_d); end
    total++; if (vo_d !== 1'b1 || pt_d !== 1'b0) begin bad++; $display("FAIL rel_vo_tick got=vo%b pt%b want=vo1 pt0", vo_d, pt_d); end
    @(negedge clk);
    total++; if (px_d !== 10'd0 || pt_d !== 1'b1 || ls_d !== 1'b0 || fs_d !== 1'b0) begin bad++; $display("FAIL rel_c1 got=x%0d pt%b ls%b fs%b want=x0 pt1 ls0 fs0", px_d, pt_d, ls_d, fs_d); end
    @(negedge clk);
    total++; if (px_d !== 10'd1) begin bad++; $display("FAIL rel_c2_pix_x got=%0d want=1", px_d); end
  endtask

  task automatic test_small_clkdiv1();
    int pt_low = 0, hs_cnt = 0, hs_first = -1, vs_cnt = 0, vs_first = -1;
    int ls_n = 0, fs_n = 0, fs_second = -1;
    rst_s = 1'b1;
    for (int c = 0; c < 196; c++) begin
      @(negedge clk);
      if (pt_s !== 1'b1) pt_low++;
      if (c < 14 && hs_s == 1'b0) begin hs_cnt++; if (hs_first < 0) hs_first = c; end
      if (c < 98 && vs_s == 1'b0) begin vs_cnt++; if (vs_first < 0) vs_first = c; end
      if (ls_s == 1'b1) ls_n++;
      if (fs_s == 1'b1) begin fs_n++; if (c > 0 && fs_second < 0) fs_second = c; end
      if (c == 0) begin
        total++; if (ls_s !== 1'b1 || fs_s !== 1'b1) begin bad++; $display("FAIL s_first_strobes got=ls%b fs%b want=11", ls_s, fs_s); end
      end
      if (c == 7) begin
        total++; if (vo_s !== 1'b1) begin bad++; $display("FAIL s_vo_x7 got=%b want=1", vo_s); end
      end
      if (c == 8) begin
        total++; if (vo_s !== 1'b0) begin bad++; $display("FAIL s_vo_x8 got=%b want=0", vo_s); end
      end
      if (c == 13) begin
        total++; if (px_s !== 10'd13 || py_s !== 10'd0) begin bad++; $display("FAIL s_line_end got=%0d,%0d want=13,0", px_s, py_s); end
      end
      if (c == 42) begin
        total++; if (vo_s !== 1'b1 || py_s !== 10'd3) begin bad++; $display("FAIL s_y3 got=vo%b y%0d want=vo1 y3", vo_s, py_s); end
      end
      if (c == 56) begin
        total++; if (vo_s !== 1'b0 || py_s !== 10'd4) begin bad++; $display("FAIL s_y4 got=vo%b y%0d want=vo0 y4", vo_s, py_s); end
      end
      if (c == 97) begin
        total++; if (px_s !== 10'd13 || py_s !== 10'd6) begin bad++; $display("FAIL s_frame_end got=%0d,%0d want=13,6", px_s, py_s); end
      end
      if (c == 98) begin
        total++; if (px_s !== 10'd0 || py_s !== 10'd0 || ls_s !== 1'b1 || fs_s !== 1'b1) begin bad++; $display("FAIL s_wrap got=%0d,%0d ls%b fs%b want=0,0 ls1 fs1", px_s, py_s, ls_s, fs_s); end
      end
    end
    total++; if (pt_low != 0) begin bad++; $display("FAIL s_tick_const got=%0d low clocks want=0", pt_low); end
    total++; if (hs_cnt != 2 || hs_first != 10) begin bad++; $display("FAIL s_hsync got=%0d from %0d want=2 from 10", hs_cnt, hs_first); end
    total++; if (vs_cnt != 14 || vs_first != 70) begin bad++; $display("FAIL s_vsync got=%0d from %0d want=14 from 70", vs_cnt, vs_first); end
    total++; if (ls_n != 14) begin bad++; $display("FAIL s_line_count got=%0d want=14", ls_n); end
    total++; if (fs_n != 2 || fs_second != 98) begin bad++; $display("FAIL s_frame got=%0d second@%0d want=2 second@98", fs_n, fs_second); end
  endtask

  task automatic test_polarity();
    int hs_cnt = 0, hs_first = -1, vs_cnt = 0, vs_first = -1;
    rst_p = 1'b1;
    for (int c = 0; c < 98; c++) begin
      @(negedge clk);
      if (c < 14 && hs_p == 1'b1) begin hs_cnt++; if (hs_first < 0) hs_first = c; end
      if (vs_p == 1'b1) begin vs_cnt++; if (vs_first < 0) vs_first = c; end
      if (c == 0) begin
        total++; if (hs_p !== 1'b0 || vs_p !== 1'b0) begin bad++; $display("FAIL p_idle got=hs%b vs%b want=hs0 vs0", hs_p, vs_p); end
      end
    end
    total++; if (hs_cnt != 2 || hs_first != 10) begin bad++; $display("FAIL p_hsync got=%0d from %0d want=2 from 10", hs_cnt, hs_first); end
    total++; if (vs_cnt != 14 || vs_first != 70) begin bad++; $display("FAIL p_vsync got=%0d from %0d want=14 from 70", vs_cnt, vs_first); end
  endtask

  task automatic test_clkdiv3();
    int tick_n = 0, tick_misplaced = 0, ls_n = 0, ls_second = -1;
    rst_3 = 1'b1;
    for (int c = 0; c < 4800; c++) begin
      @(negedge clk);
      if (c < 2400 && pt_3 == 1'b1) tick_n++;
      if (pt_3 !== ((c % 3) == 2)) tick_misplaced++;
      if (ls_3 == 1'b1) begin ls_n++; if (c > 0 && ls_second < 0) ls_second = c; end
      if (c == 0) begin
        total++; if (ls_3 !== 1'b1 || px_3 !== 10'd0) begin bad++; $display("FAIL d3_first got=ls%b x%0d want=ls1 x0", ls_3, px_3); end
      end
      if (c == 2) begin
        total++; if (px_3 !== 10'd0 || ls_3 !== 1'b0 || pt_3 !== 1'b1) begin bad++; $display("FAIL d3_c2 got=x%0d ls%b pt%b want=x0 ls0 pt1", px_3, ls_3, pt_3); end
      end
      if (c == 3) begin
        total++; if (px_3 !== 10'd1) begin bad++; $display("FAIL d3_c3_pix_x got=%0d want=1", px_3); end
      end
      if (c == 2400) begin
        total++; if (px_3 !== 10'd0 || py_3 !== 10'd1) begin bad++; $display("FAIL d3_line2 got=%0d,%0d want=0,1", px_3, py_3); end
      end
    end
    total++; if (tick_n != 800) begin bad++; $display("FAIL d3_tick_count got=%0d want=800", tick_n); end
    total++; if (tick_misplaced != 0) begin bad++; $display("FAIL d3_tick_phase got=%0d misplaced want=0", tick_misplaced); end
    total++; if (ls_n != 2 || ls_second != 2400) begin bad++; $display("FAIL d3_line got=%0d second@%0d want=2 second@2400", ls_n, ls_second); end
  endtask

  initial begin
    test_reset();
    test_default_line();
    test_mid_reset();
    test_small_clkdiv1();
    test_polarity();
    test_clkdiv3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
